// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_control_pkg
// Opcode/funct encodings, ALU control codes, instruction indices and FSM states.
// Revision: 1.0
// ============================================================================
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    // One-hot instruction vector positions; R-type instructions occupy 0..8.
    localparam int INSN_N = 15;
    localparam int I_ADD  = 0;
    localparam int I_ADDU = 1;
    localparam int I_SUB  = 2;
    localparam int I_SUBU = 3;
    localparam int I_AND  = 4;
    localparam int I_OR   = 5;
    localparam int I_SLL  = 6;
    localparam int I_SLT  = 7;
    localparam int I_SLTU = 8;
    localparam int I_ADDI = 9;
    localparam int I_LW   = 10;
    localparam int I_SW   = 11;
    localparam int I_BEQ  = 12;
    localparam int I_BNE  = 13;
    localparam int I_BGTZ = 14;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// mc_decode
// Combinational instruction classifier and static datapath control decode.
// Revision: 1.0
// ============================================================================
module mc_decode
    import multicycle_control_pkg::*;
#(
    parameter int BGTZ_EN = 1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       reg_dst,
    output logic       ext_op,
    output logic       alu_src,
    output logic [2:0] alu_ctr,
    output logic       mem_to_reg,
    output logic       is_load,
    output logic       is_store,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_bgtz,
    output logic       illegal
);

    logic [INSN_N-1:0] w_insn;

    always_comb begin
        w_insn = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  w_insn[I_ADD]  = 1'b1;
                    FN_ADDU: w_insn[I_ADDU] = 1'b1;
                    FN_SUB:  w_insn[I_SUB]  = 1'b1;
                    FN_SUBU: w_insn[I_SUBU] = 1'b1;
                    FN_AND:  w_insn[I_AND]  = 1'b1;
                    FN_OR:   w_insn[I_OR]   = 1'b1;
                    FN_SLL:  w_insn[I_SLL]  = 1'b1;
                    FN_SLT:  w_insn[I_SLT]  = 1'b1;
                    FN_SLTU: w_insn[I_SLTU] = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: w_insn[I_ADDI] = 1'b1;
            OP_LW:   w_insn[I_LW]   = 1'b1;
            OP_SW:   w_insn[I_SW]   = 1'b1;
            OP_BEQ:  w_insn[I_BEQ]  = 1'b1;
            OP_BNE:  w_insn[I_BNE]  = 1'b1;
            OP_BGTZ: w_insn[I_BGTZ] = (BGTZ_EN != 0);
            default: ;
        endcase
    end

    // Loads and stores compute their address with the non-trapping add.
    always_comb begin
        alu_ctr = ALU_ADD;
        if (w_insn[I_AND])                                     alu_ctr = ALU_AND;
        if (w_insn[I_OR])                                      alu_ctr = ALU_OR;
        if (w_insn[I_ADDU] | w_insn[I_LW] | w_insn[I_SW])      alu_ctr = ALU_ADDU;
        if (w_insn[I_SLL])                                     alu_ctr = ALU_SLL;
        if (w_insn[I_SUB] | w_insn[I_SUBU] | w_insn[I_BEQ] |
            w_insn[I_BNE] | w_insn[I_BGTZ])                    alu_ctr = ALU_SUB;
        if (w_insn[I_SLT])                                     alu_ctr = ALU_SLT;
        if (w_insn[I_SLTU])                                    alu_ctr = ALU_SLTU;
    end

    assign reg_dst    = |w_insn[I_SLTU:I_ADD];
    assign ext_op     = w_insn[I_ADDI] | w_insn[I_LW] | w_insn[I_SW];
    assign alu_src    = ext_op;
    assign mem_to_reg = w_insn[I_LW];
    assign is_load    = w_insn[I_LW];
    assign is_store   = w_insn[I_SW];
    assign is_beq     = w_insn[I_BEQ];
    assign is_bne     = w_insn[I_BNE];
    assign is_bgtz    = w_insn[I_BGTZ];
    assign illegal    = ~|w_insn;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control
// FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR, with illegal-op halt.
// Revision: 1.0
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BGTZ_EN  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    input  logic            dmem_ready,
    input  logic            equal,
    input  logic            sign,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            RegWr,
    output logic            RegDst,
    output logic            ExtOp,
    output logic            ALUSrc,
    output logic [2:0]      ALUctr,
    output logic            MemWr,
    output logic            MemtoReg,
    output logic            halted
);

    state_t      r_state;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_bgtz;
    logic        w_is_branch;
    logic        w_illegal;
    logic        w_taken;
    logic [31:0] w_offset;

    mc_decode #(
        .BGTZ_EN (BGTZ_EN)
    ) u_decode (
        .opcode     (ir[31:26]),
        .funct      (ir[5:0]),
        .reg_dst    (RegDst),
        .ext_op     (ExtOp),
        .alu_src    (ALUSrc),
        .alu_ctr    (ALUctr),
        .mem_to_reg (MemtoReg),
        .is_load    (w_is_load),
        .is_store   (w_is_store),
        .is_beq     (w_is_beq),
        .is_bne     (w_is_bne),
        .is_bgtz    (w_is_bgtz),
        .illegal    (w_illegal)
    );

    assign imem_addr   = pc;
    assign w_offset    = branch_offset(ir[15:0]);
    assign w_is_branch = w_is_beq | w_is_bne | w_is_bgtz;
    assign w_taken     = (w_is_beq  &  equal)
                       | (w_is_bne  & ~equal)
                       | (w_is_bgtz & ~equal & ~sign);

    // Strobes are registered and set on the transition into the state that
    // owns them, so the first FETCH after reset spends one cycle raising imem_req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            halted   <= 1'b0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            RegWr    <= 1'b0;
            MemWr    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        ir       <= imem_rdata;
                        pc       <= pc + PC_W'(4);
                        imem_req <= 1'b0;
                        r_state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        halted  <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_branch) begin
                        if (w_taken) begin
                            pc <= pc + w_offset[PC_W-1:0];
                        end
                        imem_req <= 1'b1;
                        r_state  <= ST_FETCH;
                    end else if (w_is_load | w_is_store) begin
                        dmem_req <= 1'b1;
                        MemWr    <= w_is_store;
                        r_state  <= ST_MEM;
                    end else begin
                        RegWr   <= 1'b1;
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        MemWr    <= 1'b0;
                        if (w_is_store) begin
                            imem_req <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            RegWr   <= 1'b1;
                            r_state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    RegWr    <= 1'b0;
                    imem_req <= 1'b1;
                    r_state  <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    halted  <= 1'b1;
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control
// Directed checks of fetch/execute sequencing, branches, halt and reset.
// Revision: 1.0
// ============================================================================
module tb_multicycle_control;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_ready = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            dmem_ready = 1'b0;
    logic            equal = 1'b0;
    logic            sign = 1'b0;

    logic            imem_req, dmem_req, RegWr, RegDst, ExtOp, ALUSrc, MemWr, MemtoReg, halted;
    logic [PC_W-1:0] imem_addr, pc;
    logic [31:0]     ir;
    logic [2:0]      ALUctr;

    logic            nb_imem_req, nb_dmem_req, nb_RegWr, nb_RegDst, nb_ExtOp, nb_ALUSrc;
    logic            nb_MemWr, nb_MemtoReg, nb_halted;
    logic [PC_W-1:0] nb_imem_addr, nb_pc;
    logic [31:0]     nb_ir;
    logic [2:0]      nb_ALUctr;

    always #5 clk = ~clk;

    multicycle_control #(.PC_W(PC_W), .RESET_PC(32'h100), .BGTZ_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .equal(equal), .sign(sign),
        .ir(ir), .pc(pc), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp), .ALUSrc(ALUSrc),
        .ALUctr(ALUctr), .MemWr(MemWr), .MemtoReg(MemtoReg), .halted(halted)
    );

    multicycle_control #(.PC_W(PC_W), .RESET_PC(32'h100), .BGTZ_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .imem_req(nb_imem_req), .imem_addr(nb_imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(nb_dmem_req), .dmem_ready(dmem_ready), .equal(equal), .sign(sign),
        .ir(nb_ir), .pc(nb_pc), .RegWr(nb_RegWr), .RegDst(nb_RegDst), .ExtOp(nb_ExtOp), .ALUSrc(nb_ALUSrc),
        .ALUctr(nb_ALUctr), .MemWr(nb_MemWr), .MemtoReg(nb_MemtoReg), .halted(nb_halted)
    );

    int checks = 0;
    int errors = 0;

    // Per-instruction observations collected by exec_instr.
    int          n_cyc, n_ireq, n_dreq, n_regwr, n_memwr, regwr_cyc, halt_cyc;
    bit          got_next;
    logic        wb_memtoreg, d_regdst, d_extop, d_alusrc;
    logic [2:0]  d_aluctr;
    logic [31:0] pc_dec;

    logic [31:0] r_tbl   [9] = '{32'h01095020, 32'h01095021, 32'h01095022, 32'h01095023,
                                 32'h01095024, 32'h01095025, 32'h00094080, 32'h0109502A,
                                 32'h0109502B};
    logic [2:0]  r_alu   [9] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0, 3'd1, 3'd5, 3'd3, 3'd7};

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Must be entered on a negedge where imem_req is high; returns on the
    // negedge where the next fetch request appears, or after limit cycles.
    task automatic exec_instr(input logic [31:0] instr, input int iwait, input int dwait,
                              input logic eq, input logic sg, input int limit);
        int iw, dw;
        bit dropped;
        n_cyc = 0; n_ireq = 0; n_dreq = 0; n_regwr = 0; n_memwr = 0;
        regwr_cyc = 0; halt_cyc = 0; got_next = 1'b0; wb_memtoreg = 1'b0;
        iw = 0; dw = 0; dropped = 1'b0;
        equal = eq; sign = sg;
        for (int c = 1; c <= limit; c++) begin
            if (!imem_req) dropped = 1'b1;
            else if (dropped) begin
                got_next = 1'b1;
                break;
            end
            n_cyc = c;
            if (c == 2) begin
                d_regdst = RegDst; d_extop = ExtOp; d_alusrc = ALUSrc; d_aluctr = ALUctr; pc_dec = pc;
            end
            if (imem_req) begin
                n_ireq++;
                if (iw >= iwait) begin imem_ready = 1'b1; imem_rdata = instr; end
                else begin imem_ready = 1'b0; iw++; end
            end else imem_ready = 1'b0;
            if (dmem_req) begin
                n_dreq++;
                if (dw >= dwait) dmem_ready = 1'b1;
                else begin dmem_ready = 1'b0; dw++; end
            end else dmem_ready = 1'b0;
            if (RegWr) begin
                n_regwr++;
                if (regwr_cyc == 0) regwr_cyc = c;
                wb_memtoreg = MemtoReg;
            end
            if (MemWr) n_memwr++;
            if (halted && halt_cyc == 0) halt_cyc = c;
            @(negedge clk);
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h100); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h exp 0", ir); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
        checks++; if ({imem_req, dmem_req, RegWr, MemWr} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b exp 0000", {imem_req, dmem_req, RegWr, MemWr});
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL reset_first_fetch: got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr);
        end
    endtask

    task automatic test_addi();
        exec_instr(32'h20080005, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (got_next !== 1'b1 || n_cyc !== 4) begin
            errors++; $display("FAIL addi_cycles: got next=%b cyc=%0d exp next=1 cyc=4", got_next, n_cyc);
        end
        checks++; if (regwr_cyc !== 4 || n_regwr !== 1) begin
            errors++; $display("FAIL addi_regwr: got at=%0d n=%0d exp at=4 n=1", regwr_cyc, n_regwr);
        end
        checks++; if ({d_extop, d_alusrc, d_aluctr, d_regdst} !== {1'b1, 1'b1, 3'd2, 1'b0}) begin
            errors++; $display("FAIL addi_ctrl: got ext=%b src=%b alu=%0d dst=%b exp 1 1 2 0",
                               d_extop, d_alusrc, d_aluctr, d_regdst);
        end
        checks++; if (pc_dec !== 32'h104 || imem_addr !== 32'h104) begin
            errors++; $display("FAIL addi_next_pc: got pc=%h addr=%h exp 104", pc_dec, imem_addr);
        end
    endtask

    task automatic test_rtype();
        for (int i = 0; i < 9; i++) begin
            exec_instr(r_tbl[i], 0, 0, 1'b0, 1'b0, 20);
            checks++; if (d_aluctr !== r_alu[i] || d_regdst !== 1'b1 || n_cyc !== 4 || n_regwr !== 1) begin
                errors++; $display("FAIL rtype_%0d: got alu=%0d dst=%b cyc=%0d wr=%0d exp alu=%0d dst=1 cyc=4 wr=1",
                                   i, d_aluctr, d_regdst, n_cyc, n_regwr, r_alu[i]);
            end
        end
    endtask

    task automatic test_lw_sw();
        do_reset();
        @(negedge clk);
        exec_instr(32'h8C090004, 2, 3, 1'b0, 1'b0, 40);
        checks++; if (n_ireq !== 3 || n_dreq !== 4) begin
            errors++; $display("FAIL lw_wait_reqs: got ireq=%0d dreq=%0d exp 3 4", n_ireq, n_dreq);
        end
        checks++; if (n_regwr !== 1 || wb_memtoreg !== 1'b1 || n_memwr !== 0) begin
            errors++; $display("FAIL lw_wait_wb: got wr=%0d m2r=%b memwr=%0d exp 1 1 0", n_regwr, wb_memtoreg, n_memwr);
        end
        // Zero-wait lw is 5 cycles; two fetch and three data wait states add 5.
        checks++; if (n_cyc !== 10 || got_next !== 1'b1) begin
            errors++; $display("FAIL lw_wait_total: got %0d exp 10", n_cyc);
        end
        exec_instr(32'h8C090004, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (n_cyc !== 5 || regwr_cyc !== 5) begin
            errors++; $display("FAIL lw_zero_wait: got cyc=%0d wr_at=%0d exp 5 5", n_cyc, regwr_cyc);
        end
        exec_instr(32'hAC090004, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (n_cyc !== 4 || n_memwr !== 1 || n_dreq !== 1 || n_regwr !== 0) begin
            errors++; $display("FAIL sw_zero_wait: got cyc=%0d memwr=%0d dreq=%0d wr=%0d exp 4 1 1 0",
                               n_cyc, n_memwr, n_dreq, n_regwr);
        end
        checks++; if (imem_addr !== 32'h10C) begin
            errors++; $display("FAIL sw_next_pc: got %h exp 10c", imem_addr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        exec_instr(32'h1000003F, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (n_cyc !== 3 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL beq_fwd: got cyc=%0d addr=%h exp 3 200", n_cyc, imem_addr);
        end
        exec_instr(32'h1000FFFF, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (imem_addr !== 32'h200 || n_regwr !== 0 || n_memwr !== 0) begin
            errors++; $display("FAIL beq_taken_back: got addr=%h wr=%0d memwr=%0d exp 200 0 0", imem_addr, n_regwr, n_memwr);
        end
        exec_instr(32'h1000FFFF, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (imem_addr !== 32'h204 || n_cyc !== 3 || n_regwr !== 0 || n_memwr !== 0) begin
            errors++; $display("FAIL beq_not_taken: got addr=%h cyc=%0d exp 204 3", imem_addr, n_cyc);
        end
        exec_instr(32'h1400FFFF, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (imem_addr !== 32'h204) begin
            errors++; $display("FAIL bne_taken: got %h exp 204", imem_addr);
        end
        exec_instr(32'h1400FFFF, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (imem_addr !== 32'h208) begin
            errors++; $display("FAIL bne_not_taken: got %h exp 208", imem_addr);
        end
    endtask

    task automatic test_bgtz();
        do_reset();
        @(negedge clk);
        exec_instr(32'h1000FFC3, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (imem_addr !== 32'h10) begin
            errors++; $display("FAIL bgtz_setup: got %h exp 10", imem_addr);
        end
        exec_instr(32'h1C000003, 0, 0, 1'b0, 1'b0, 20);
        checks++; if (imem_addr !== 32'h20 || n_cyc !== 3) begin
            errors++; $display("FAIL bgtz_taken: got addr=%h cyc=%0d exp 20 3", imem_addr, n_cyc);
        end
        do_reset();
        @(negedge clk);
        exec_instr(32'h1000FFC3, 0, 0, 1'b1, 1'b0, 20);
        exec_instr(32'h1C000003, 0, 0, 1'b0, 1'b1, 20);
        checks++; if (imem_addr !== 32'h14) begin
            errors++; $display("FAIL bgtz_negative: got %h exp 14", imem_addr);
        end
        exec_instr(32'h1C000003, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (imem_addr !== 32'h18) begin
            errors++; $display("FAIL bgtz_zero: got %h exp 18", imem_addr);
        end
    endtask

    task automatic test_bgtz_disabled();
        int stray;
        do_reset();
        @(negedge clk);
        exec_instr(32'h1000FFC3, 0, 0, 1'b1, 1'b0, 20);
        checks++; if (nb_imem_req !== 1'b1 || nb_imem_addr !== 32'h10) begin
            errors++; $display("FAIL nb_fetch: got req=%b addr=%h exp 1 10", nb_imem_req, nb_imem_addr);
        end
        exec_instr(32'h1C000003, 0, 0, 1'b0, 1'b0, 3);
        checks++; if (nb_halted !== 1'b1) begin
            errors++; $display("FAIL nb_halted: got %b exp 1", nb_halted);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            if (nb_imem_req || nb_dmem_req || nb_RegWr || nb_MemWr || !nb_halted) stray++;
            @(negedge clk);
        end
        checks++; if (stray !== 0) begin
            errors++; $display("FAIL nb_absorbing: got %0d active cycles exp 0", stray);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        exec_instr(32'h0000003F, 0, 0, 1'b0, 1'b0, 8);
        checks++; if (halt_cyc !== 3 || halted !== 1'b1) begin
            errors++; $display("FAIL illegal_halt: got at=%0d halted=%b exp 3 1", halt_cyc, halted);
        end
        checks++; if (got_next !== 1'b0 || n_ireq !== 1 || n_regwr !== 0 || n_dreq !== 0) begin
            errors++; $display("FAIL illegal_quiet: got next=%b ireq=%0d wr=%0d dreq=%0d exp 0 1 0 0",
                               got_next, n_ireq, n_regwr, n_dreq);
        end
        do_reset();
        checks++; if (halted !== 1'b0 || pc !== 32'h100) begin
            errors++; $display("FAIL illegal_clear: got halted=%b pc=%h exp 0 100", halted, pc);
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL illegal_restart: got req=%b addr=%h exp 1 100", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        @(negedge clk);
        exec_instr(32'hAC090004, 0, 100, 1'b0, 1'b0, 4);
        checks++; if (dmem_req !== 1'b1 || MemWr !== 1'b1) begin
            errors++; $display("FAIL mem_pending: got dreq=%b memwr=%b exp 1 1", dmem_req, MemWr);
        end
        rst_n = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; dmem_ready = 1'b0;
        checks++; if (dmem_req !== 1'b0 || MemWr !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h100) begin
            errors++; $display("FAIL mem_reset: got dreq=%b memwr=%b ireq=%b pc=%h exp 0 0 0 100",
                               dmem_req, MemWr, imem_req, pc);
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL mem_reset_refetch: got ireq=%b addr=%h dreq=%b exp 1 100 0",
                               imem_req, imem_addr, dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_lw_sw();
        test_branch();
        test_bgtz();
        test_bgtz_disabled();
        test_illegal();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
